// File: rtl/zigbee_chip_spreader_pkg.sv
// Shared constants and types for the O-QPSK chip spreader.
// Table bit k is chip c_k; c_0 leaves the spreader first.
package zigbee_pkg;

    localparam int CHIPS_PER_SYM = 32;
    localparam int SYM_W         = 4;
    localparam int IDX_W         = 5;

    // Symbols 1-7 rotate symbol 0 by 4 chips each; 8-15 invert the odd chips of 0-7.
    localparam logic [15:0][31:0] CHIP_TABLE = {
        32'h1DEE0693, 32'h31DEE069, 32'h931DEE06, 32'h6931DEE0,
        32'h06931DEE, 32'hE06931DE, 32'hEE06931D, 32'hDEE06931,
        32'hB744AC39, 32'h9B744AC3, 32'h39B744AC, 32'hC39B744A,
        32'hAC39B744, 32'h4AC39B74, 32'h44AC39B7, 32'h744AC39B
    };

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } spr_state_t;

endpackage

// File: rtl/zigbee_chip_spreader_if.sv
// Symbol input handshake plus the chip stream towards the MSK modulator.
interface zigbee_chip_spreader_if;
    import zigbee_pkg::*;

    logic [SYM_W-1:0] i_sym;
    logic             i_sym_valid;
    logic             o_sym_ready;
    logic             o_chip;
    logic             o_empty;
    logic             i_ready;
    logic [IDX_W-1:0] o_chip_idx;
    logic             o_busy;

    modport master (
        output i_sym, i_sym_valid, i_ready,
        input  o_sym_ready, o_chip, o_empty, o_chip_idx, o_busy
    );

    modport slave (
        input  i_sym, i_sym_valid, i_ready,
        output o_sym_ready, o_chip, o_empty, o_chip_idx, o_busy
    );

endinterface

// File: rtl/zigbee_chip_spreader_fifo.sv
// Synchronous symbol FIFO; read data is the combinational head, pop takes effect at the edge.
// rdy_o is registered from the next count, so a push is never accepted while full.
module zigbee_sym_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       dat_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       dat_o,
    output logic [$clog2(DEPTH):0] count_nxt_o,
    output logic                   empty_o,
    output logic                   rdy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             rdy_q;
    logic             push_ok, pop_ok;

    assign push_ok = push_i & rdy_q;
    assign pop_ok  = pop_i & (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            rdy_q   <= (count_d < FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= dat_i;
    end

    assign dat_o       = mem_q[rd_ptr_q];
    assign count_nxt_o = count_d;
    assign empty_o     = (count_q == '0);
    assign rdy_o       = rdy_q;

endmodule

// File: rtl/zigbee_chip_spreader.sv
// Expands queued 4-bit symbols into 32-chip PN sequences, one chip per i_ready rising edge.
// First chip appears two edges after the symbol is accepted; symbols chain without a gap.
module zigbee_chip_spreader
    import zigbee_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input logic                   clk,
    input logic                   reset,
    zigbee_chip_spreader_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHIPS_PER_SYM - 1);

    spr_state_t               state_q, state_d;
    logic [CHIPS_PER_SYM-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     ready_q, empty_q, busy_q;
    logic                     adv, pop;
    logic                     fifo_empty, fifo_rdy;
    logic [SYM_W-1:0]         head;
    logic [CW-1:0]            count_nxt;

    zigbee_sym_fifo #(
        .WIDTH (SYM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (bus.i_sym_valid),
        .dat_i       (bus.i_sym),
        .pop_i       (pop),
        .dat_o       (head),
        .count_nxt_o (count_nxt),
        .empty_o     (fifo_empty),
        .rdy_o       (fifo_rdy)
    );

    // A held-high i_ready spans the modulator's inter-half-sine gap; only its rise counts.
    assign adv = bus.i_ready & ~ready_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = CHIP_TABLE[head];
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (adv) begin
                    if (idx_q != LAST_IDX) begin
                        shreg_d = shreg_q >> 1;
                        idx_d   = idx_q + 1'b1;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = CHIP_TABLE[head];
                        idx_d   = '0;
                    end else begin
                        shreg_d = '0;
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            empty_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            ready_q <= bus.i_ready;
            // Falls one edge after the load, rises on the same edge as the return to IDLE.
            empty_q <= (state_d == IDLE) || (state_q == IDLE);
            busy_q  <= (state_d == SEND) || (count_nxt != '0);
        end
    end

    assign bus.o_chip      = shreg_q[0];
    assign bus.o_chip_idx  = idx_q;
    assign bus.o_empty     = empty_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_sym_ready = fifo_rdy;

endmodule
